lsu_ctrl: RTL and testbench

Load/store unit controller between the memory stage and the data-memory bus. It accepts one RV32I load or store per instruction and converts it into a word-aligned bus request with byte enables. It stalls the pipeline until the bus grants the request and, for loads, returns data. Load data is lane-extracted, sign- or zero-extended and registered as `lsu_rdata`, which the write-back stage selects when `wb_sel = 2'b01`.

---
 rtl/lsu_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: turns one RV32I load/store into a word-aligned
// bus request with byte enables, stalls the pipeline, and extends load data.
module lsu_ctrl #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            lsu_stall,
  output logic [XLEN-1:0] lsu_rdata,
  output logic            lsu_misalign,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int unsigned OFF_W = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_mem_req;
  logic              r_mem_we;
  logic [XLEN-1:0]   r_mem_addr;
  logic [3:0]        r_mem_be;
  logic [XLEN-1:0]   r_mem_wdata;
  logic [XLEN-1:0]   r_rdata;
  logic [2:0]        r_funct3;
  logic [OFF_W-1:0]  r_off;

  logic              w_misalign;
  logic              w_issue;
  logic              w_gnt;
  logic              w_capture;
  logic [3:0]        w_be;
  logic [XLEN-1:0]   w_wdata;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [XLEN-1:0]   w_ext;

  // funct3[1:0]: 00 byte, 01 halfword, 1x word (undefined encodings fall here)
  always_comb begin
    w_misalign = 1'b0;
    case (req_funct3[1:0])
      2'b00:   w_misalign = 1'b0;
      2'b01:   w_misalign = req_addr[0];
      default: w_misalign = (req_addr[1:0] != 2'b00);
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (req_valid && !w_misalign) w_state_nxt = S_REQ;
      S_REQ:  if (mem_gnt) w_state_nxt = r_mem_we ? S_DONE : S_WAIT;
      S_WAIT: if (mem_rvalid) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Stall/misalign outputs and datapath strobes
  always_comb begin
    lsu_stall    = 1'b0;
    lsu_misalign = 1'b0;
    w_issue      = 1'b0;
    w_gnt        = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        lsu_misalign = req_valid & w_misalign;
        lsu_stall    = req_valid & ~w_misalign;
        w_issue      = req_valid & ~w_misalign;
      end
      S_REQ: begin
        lsu_stall = 1'b1;
        w_gnt     = mem_gnt;
      end
      S_WAIT: begin
        lsu_stall = 1'b1;
        w_capture = mem_rvalid;
      end
      default: begin
        lsu_stall = 1'b0;
      end
    endcase
  end

  // Store lane steering; loads request the full word with no write data
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = '0;
    if (req_we) begin
      case (req_funct3[1:0])
        2'b00: begin
          w_be    = 4'b0001 << req_addr[1:0];
          w_wdata = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{req_wdata[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = req_wdata;
        end
      endcase
    end
  end

  // Load lane extraction and extension
  always_comb begin
    w_byte = 8'h00;
    case (r_off)
      2'd0:    w_byte = mem_rdata[7:0];
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    w_ext  = mem_rdata;
    case (r_funct3)
      3'b000:  w_ext = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b100:  w_ext = {{(XLEN-8){1'b0}}, w_byte};
      3'b001:  w_ext = {{(XLEN-16){w_half[15]}}, w_half};
      3'b101:  w_ext = {{(XLEN-16){1'b0}}, w_half};
      default: w_ext = mem_rdata;
    endcase
  end

  // Bus request registers, held from issue until grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= 4'b0000;
      r_mem_wdata <= '0;
      r_funct3    <= 3'b000;
      r_off       <= '0;
    end else if (w_issue) begin
      r_mem_req   <= 1'b1;
      r_mem_we    <= req_we;
      r_mem_addr  <= {req_addr[XLEN-1:2], 2'b00};
      r_mem_be    <= w_be;
      r_mem_wdata <= w_wdata;
      r_funct3    <= req_funct3;
      r_off       <= req_addr[1:0];
    end else if (w_gnt) begin
      r_mem_req   <= 1'b0;
    end
  end

  // Load result only changes on a captured read response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (w_capture) begin
      r_rdata <= w_ext;
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_be    = r_mem_be;
  assign mem_wdata = r_mem_wdata;
  assign lsu_rdata = r_rdata;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: scoreboard of expected lsu_rdata values,
// bus-field, stall-length and misalignment checks via immediate assertions.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        lsu_stall;
  logic [31:0] lsu_rdata;
  logic        lsu_misalign;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] sb_q[$];
  logic [31:0] exp_hold = 32'h0;

  // request presented by the pipeline during a DONE cycle
  logic        nxt_valid = 1'b0;
  logic        nxt_we    = 1'b0;
  logic [2:0]  nxt_f3    = 3'b000;
  logic [31:0] nxt_addr  = 32'h0;
  logic [31:0] nxt_wdata = 32'h0;

  lsu_ctrl #(.XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .lsu_stall    (lsu_stall),
    .lsu_rdata    (lsu_rdata),
    .lsu_misalign (lsu_misalign),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_gnt      (mem_gnt),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(d >> (8 * int'(off)));
    h = off[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return d;
    endcase
  endfunction

  // One aligned access: IDLE cycle, REQ (gnt after gnt_dly), WAIT (rvalid after rv_dly), DONE
  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input int gnt_dly, input int rv_dly,
                     input logic [31:0] rdata, input logic [3:0] exp_be,
                     input logic [31:0] exp_wd, input string tag);
    int          stall_n = 0;
    int          req_n   = 0;
    int          k       = 0;
    int          j       = 0;
    int          cyc     = 0;
    int          phase   = 1;
    logic        done    = 1'b0;
    logic [31:0] exp;
    if (!we) exp_hold = model_load(f3, addr[1:0], rdata);
    sb_q.push_back(exp_hold);

    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    #1;
    chk({tag, " idle mem_req"}, 32'(mem_req), 32'd0);
    if (lsu_stall) stall_n++;

    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (phase == 1) begin
        if (k == 0) begin
          chk({tag, " mem_addr"},  mem_addr, addr & 32'hFFFF_FFFC);
          chk({tag, " mem_be"},    32'(mem_be), 32'(exp_be));
          chk({tag, " mem_wdata"}, mem_wdata, exp_wd);
          chk({tag, " mem_we"},    32'(mem_we), 32'(we));
        end
        mem_gnt = (k == gnt_dly);
      end else if (phase == 2) begin
        mem_rvalid = (j == rv_dly);
        mem_rdata  = (j == rv_dly) ? rdata : 32'h5A5A_0F0F;
      end else begin
        req_valid = nxt_valid; req_we = nxt_we; req_funct3 = nxt_f3;
        req_addr = nxt_addr; req_wdata = nxt_wdata;
      end
      #1;
      if (mem_req) req_n++;
      if (lsu_stall) stall_n++;
      if (phase == 3) begin
        exp = sb_q.pop_front();
        chk({tag, " done stall"}, 32'(lsu_stall), 32'd0);
        chk({tag, " lsu_rdata"}, lsu_rdata, exp);
        done = 1'b1;
      end else if (phase == 1) begin
        if (mem_gnt) phase = we ? 3 : 2;
        k++;
      end else begin
        if (mem_rvalid) phase = 3;
        j++;
      end
    end
    chk({tag, " completed"}, 32'(done), 32'd1);
    chk({tag, " stall cycles"}, 32'(stall_n),
        32'(2 + gnt_dly + (we ? 0 : rv_dly + 1)));
    chk({tag, " mem_req cycles"}, 32'(req_n), 32'(gnt_dly + 1));
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    nxt_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;

    // reset state
    #12;
    chk("rst mem_req",   32'(mem_req), 32'd0);
    chk("rst mem_be",    32'(mem_be), 32'd0);
    chk("rst mem_addr",  mem_addr, 32'd0);
    chk("rst lsu_rdata", lsu_rdata, 32'd0);
    chk("rst stall",     32'(lsu_stall), 32'd0);
    chk("rst misalign",  32'(lsu_misalign), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // loads: word, signed/unsigned byte
    txn(1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 4'b1111, 32'h0, "lw");
    txn(1'b0, 3'b000, 32'h103, 32'h0, 0, 0, 32'h80FF1234, 4'b1111, 32'h0, "lb");
    txn(1'b0, 3'b100, 32'h103, 32'h0, 0, 0, 32'h80FF1234, 4'b1111, 32'h0, "lbu");

    // store halfword with delayed grant; lsu_rdata must hold 0x80
    txn(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 3, 0, 32'h0, 4'b1100, 32'hABCDABCD, "sh");

    // misaligned word and halfword: no stall, no bus traffic
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h101;
    #1;
    chk("mis lw misalign", 32'(lsu_misalign), 32'd1);
    chk("mis lw stall",    32'(lsu_stall), 32'd0);
    @(negedge clk);
    req_funct3 = 3'b001; req_addr = 32'h103;
    #1;
    chk("mis lh misalign", 32'(lsu_misalign), 32'd1);
    chk("mis lw mem_req",  32'(mem_req), 32'd0);
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h202;
    #1;
    chk("mis sw misalign", 32'(lsu_misalign), 32'd1);
    chk("mis lh mem_req",  32'(mem_req), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("mis after mem_req",  32'(mem_req), 32'd0);
    chk("mis after misalign", 32'(lsu_misalign), 32'd0);

    // halfword loads, store word, undefined funct3 treated as full word
    txn(1'b0, 3'b001, 32'h102, 32'h0, 1, 2, 32'h80010000, 4'b1111, 32'h0, "lh");
    txn(1'b1, 3'b010, 32'h400, 32'hCAFEF00D, 1, 0, 32'h0, 4'b1111, 32'hCAFEF00D, "sw");
    txn(1'b0, 3'b101, 32'h100, 32'h0, 0, 1, 32'h1234F00D, 4'b1111, 32'h0, "lhu");
    txn(1'b0, 3'b011, 32'h104, 32'h0, 2, 1, 32'h89ABCDEF, 4'b1111, 32'h0, "ld f3 011");

    // reset asserted during WAIT, then a spurious rvalid
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
    @(negedge clk);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    #1;
    chk("rst wait stall", 32'(lsu_stall), 32'd1);
    rst_n = 1'b0; req_valid = 1'b0;
    #1;
    chk("rst mid lsu_rdata", lsu_rdata, 32'd0);
    chk("rst mid mem_req",   32'(mem_req), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'hA5A5A5A5;
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    chk("rst post lsu_rdata", lsu_rdata, 32'd0);
    chk("rst post mem_req",   32'(mem_req), 32'd0);
    chk("rst post stall",     32'(lsu_stall), 32'd0);
    exp_hold = 32'h0;

    // back-to-back: LBU already presented during the SB's DONE cycle
    nxt_valid = 1'b1; nxt_we = 1'b0; nxt_f3 = 3'b100; nxt_addr = 32'h300; nxt_wdata = 32'h0;
    txn(1'b1, 3'b000, 32'h301, 32'h00000001, 0, 0, 32'h0, 4'b0010, 32'h01010101, "sb b2b");
    txn(1'b0, 3'b100, 32'h300, 32'h0, 0, 0, 32'h00000100, 4'b1111, 32'h0, "lbu b2b");

    @(negedge clk);
    req_valid = 1'b0;
    chk("scoreboard empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
